// File: rtl/rocc_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : rocc_mem_responder_if
// Brief     : Packed accelerator memory port. It carries a 124-bit request
//             with valid/ready and a 253-bit response with valid only.
// Revision  : 1.0 - initial release
// ============================================================================
interface rocc_mem_responder_if;
  logic         mem_req_vld;
  logic         mem_req_rdy;
  logic [123:0] mem_req;
  logic         mem_resp_vld;
  logic [252:0] mem_resp;

  // accelerator side: issues requests, consumes responses
  modport master (
    output mem_req_vld,
    output mem_req,
    input  mem_req_rdy,
    input  mem_resp_vld,
    input  mem_resp
  );

  // memory side: accepts requests, produces responses
  modport slave (
    input  mem_req_vld,
    input  mem_req,
    output mem_req_rdy,
    output mem_resp_vld,
    output mem_resp
  );
endinterface
`default_nettype wire

// File: rtl/rocc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module    : rocc_mem_responder
// Brief     : Memory-side responder for the accelerator memory port. It
//             decodes each request and performs the load or store on an
//             internal 64-bit word array. The response is returned a fixed
//             LATENCY cycles after the request is accepted.
// Revision  : 1.0 - initial release
// ============================================================================
module rocc_mem_responder #(
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 2,
  parameter int STALL_PERIOD = 0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  rocc_mem_responder_if.slave bus
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         CNT_W     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int         RESP_W    = 253;
  localparam logic [4:0] CMD_LOAD  = 5'h00;
  localparam logic [4:0] CMD_STORE = 5'h01;

  // Request fields, MSB first.
  logic [39:0] req_addr;
  logic [9:0]  req_tag;
  logic [4:0]  req_cmd;
  logic [2:0]  req_typ;
  logic        req_kill;
  logic [63:0] req_data;
  logic        unused_phys;

  assign req_addr    = bus.mem_req[123:84];
  assign req_tag     = bus.mem_req[83:74];
  assign req_cmd     = bus.mem_req[73:69];
  assign req_typ     = bus.mem_req[68:66];
  assign req_kill    = bus.mem_req[65];
  assign unused_phys = bus.mem_req[64];
  assign req_data    = bus.mem_req[63:0];

  // ---------------------------------------------------------------------------
  // Ready generation.
  // live_q holds ready low for the reset cycle.
  // The optional stall counter then drops ready once per period.
  // ---------------------------------------------------------------------------
  logic live_q;
  logic stall;
  logic rdy;
  logic accept;

  // live_q: 0 while in reset, 1 from the first cycle after release
  always_ff @(posedge clk) begin
    if (!rst) live_q <= 1'b0;
    else      live_q <= 1'b1;
  end

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      assign cnt_d = (cnt_q == CNT_W'(STALL_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
      assign stall = (cnt_q == CNT_W'(STALL_PERIOD - 1));

      // stall phase counter; held at 0 until ready first goes high
      always_ff @(posedge clk) begin
        if (!rst)        cnt_q <= '0;
        else if (live_q) cnt_q <= cnt_d;
      end
    end else begin : g_nostall
      assign stall = 1'b0;
    end
  endgenerate

  assign rdy             = live_q & ~stall;
  assign bus.mem_req_rdy = rdy;
  assign accept          = bus.mem_req_vld & rdy;

  // ---------------------------------------------------------------------------
  // Decode, array read and load extension (all in the accept cycle).
  // ---------------------------------------------------------------------------
  logic [63:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [5:0]       lane_sh;
  logic [1:0]       size;
  logic             misalign;
  logic             oob;
  logic             bad_cmd;
  logic             nack;
  logic             is_load;
  logic             is_store;
  logic [63:0]      size_mask;
  logic             sign_bit;
  logic [63:0]      rd_shift;
  logic [63:0]      load_data;
  logic [63:0]      wmask;
  logic [63:0]      wdata;
  logic [RESP_W-1:0] resp_d;

  assign idx     = req_addr[3 +: IDX_W];
  assign lane_sh = {req_addr[2:0], 3'b000};
  assign size    = req_typ[1:0];

  // request classification and extended load result
  always_comb begin
    misalign  = 1'b0;
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        misalign  = req_addr[0];
      end
      2'd2: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        misalign  = |req_addr[1:0];
      end
      default: misalign = |req_addr[2:0];
    endcase

    oob      = |req_addr[39:IDX_W+3];
    bad_cmd  = (req_cmd != CMD_LOAD) && (req_cmd != CMD_STORE);
    nack     = bad_cmd | oob | misalign;
    is_load  = (req_cmd == CMD_LOAD) && !nack;
    is_store = (req_cmd == CMD_STORE) && !nack;

    // Reads see the word as it was before this cycle's write.
    rd_shift = mem_q[idx] >> lane_sh;
    case (size)
      2'd0:    sign_bit = rd_shift[7];
      2'd1:    sign_bit = rd_shift[15];
      2'd2:    sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[63];
    endcase

    load_data = '0;
    if (is_load) begin
      load_data = (rd_shift & size_mask) |
                  ((sign_bit && !req_typ[2]) ? ~size_mask : 64'h0);
    end

    wmask = size_mask << lane_sh;
    wdata = req_data << lane_sh;

    resp_d = {req_addr, req_tag, req_cmd, req_typ, load_data,
              nack, 1'b0, is_load, load_data,
              (is_store ? req_data : 64'h0)};
  end

  // byte-lane masked store; the array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (rst && accept && !req_kill && is_store) begin
      mem_q[idx] <= (mem_q[idx] & ~wmask) | (wdata & wmask);
    end
  end

  // ---------------------------------------------------------------------------
  // Response delay line. A stage's payload is zero whenever its valid bit
  // is clear, so the output bus idles at zero without extra gating.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] vld_q;
  logic [RESP_W-1:0]  pipe_q [LATENCY];
  logic               push;

  assign push = accept & ~req_kill;

  // shift response valid/payload through LATENCY stages
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      vld_q[0]  <= push;
      pipe_q[0] <= push ? resp_d : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.mem_resp_vld = vld_q[LATENCY-1];
  assign bus.mem_resp     = pipe_q[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_rocc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module    : tb_rocc_mem_responder
// Brief     : Scoreboard bench for rocc_mem_responder.
//             Accepted requests push their expected response and due cycle.
//             A negedge monitor pops each response and compares it.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_rocc_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int STALL = 4;

  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1 = 64'h0123_4567_89AB_80EF;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  rocc_mem_responder_if bus();

  rocc_mem_responder #(
    .DEPTH       (DEPTH),
    .LATENCY     (LAT),
    .STALL_PERIOD(STALL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [252:0] resp;
    int           due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  int acc;
  int lows;
  int last_low;
  bit spacing_ok;

  // cycle counter used to time-stamp accepts and responses
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [252:0] mk(
    input logic [39:0] a,
    input logic [9:0]  t,
    input logic [4:0]  c,
    input logic [2:0]  ty,
    input logic [63:0] d,
    input logic        n,
    input logic        h,
    input logic [63:0] s
  );
    return {a, t, c, ty, d, n, 1'b0, h, d, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drives one request starting #1 after a posedge.
  // It waits, bounded, for the request to be accepted.
  // On return vld is still high, so the next call issues back-to-back.
  task automatic issue(
    input logic [39:0]  a,
    input logic [9:0]   t,
    input logic [4:0]   c,
    input logic [2:0]   ty,
    input logic         kill,
    input logic [63:0]  d,
    input logic [252:0] exp_resp
  );
    bit ok;
    ok = 1'b0;
    bus.mem_req_vld = 1'b1;
    bus.mem_req     = {a, t, c, ty, kill, 1'b0, d};
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.mem_req_rdy) begin
        if (!kill) sbq.push_back('{exp_resp, cyc + LAT});
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%0d rdy never seen", t);
    end
  endtask

  task automatic ld(input logic [39:0] a, input logic [9:0] t, input logic [2:0] ty,
                    input logic [63:0] d);
    issue(a, t, 5'h00, ty, 1'b0, 64'h0, mk(a, t, 5'h00, ty, d, 1'b0, 1'b1, 64'h0));
  endtask

  task automatic st(input logic [39:0] a, input logic [9:0] t, input logic [2:0] ty,
                    input logic [63:0] d);
    issue(a, t, 5'h01, ty, 1'b0, d, mk(a, t, 5'h01, ty, 64'h0, 1'b0, 1'b0, d));
  endtask

  task automatic nk(input logic [39:0] a, input logic [9:0] t, input logic [4:0] c,
                    input logic [2:0] ty);
    issue(a, t, c, ty, 1'b0, 64'h0, mk(a, t, c, ty, 64'h0, 1'b1, 1'b0, 64'h0));
  endtask

  // response monitor: pops the scoreboard on every valid response
  always @(negedge clk) begin
    if (bus.mem_resp_vld) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got=%h cyc=%0d", bus.mem_resp, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (bus.mem_resp !== mon_e.resp || cyc != mon_e.due) begin
          errors++;
          $display("FAIL resp got=%h at cyc %0d exp=%h at cyc %0d",
                   bus.mem_resp, cyc, mon_e.resp, mon_e.due);
        end
      end
    end else begin
      checks++;
      if (bus.mem_resp !== '0) begin
        errors++;
        $display("FAIL idle_resp_nonzero got=%h exp=0", bus.mem_resp);
      end
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_resp due=%0d now=%0d exp=%h", sbq[0].due, cyc, sbq[0].resp);
        void'(sbq.pop_front());
      end
    end
  end

  // directed stimulus
  initial begin
    bus.mem_req_vld = 1'b0;
    bus.mem_req     = '0;
    rst             = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", 64'(bus.mem_req_rdy), 64'h0);
    chk("reset_resp_vld", 64'(bus.mem_resp_vld), 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rdy_before_release_edge", 64'(bus.mem_req_rdy), 64'h0);
    @(negedge clk);
    chk("rdy_after_release", 64'(bus.mem_req_rdy), 64'h1);
    @(posedge clk);
    #1;

    // store dword then load it back-to-back
    st(40'h40, 10'd5, 3'd3, W0);
    ld(40'h40, 10'd5, 3'd3, W0);
    ld(40'h47, 10'd6, 3'd0, 64'h0000_0000_0000_0001);
    st(40'h41, 10'd7, 3'd0, 64'h0000_0000_0000_0080);
    ld(40'h41, 10'd8, 3'd0, 64'hFFFF_FFFF_FFFF_FF80);
    ld(40'h41, 10'd9, 3'd4, 64'h0000_0000_0000_0080);
    ld(40'h40, 10'd10, 3'd2, 64'hFFFF_FFFF_89AB_80EF);
    ld(40'h44, 10'd11, 3'd2, 64'h0000_0000_0123_4567);
    ld(40'h42, 10'd12, 3'd1, 64'hFFFF_FFFF_FFFF_89AB);
    ld(40'h42, 10'd13, 3'd5, 64'h0000_0000_0000_89AB);

    // nack cases: misaligned, out of range, unsupported command
    nk(40'h43, 10'd14, 5'h00, 3'd1);
    nk(40'(DEPTH * 8), 10'd15, 5'h00, 3'd3);
    nk(40'h40, 10'd16, 5'h07, 3'd3);

    // killed store: no response, no array update
    issue(40'h40, 10'd17, 5'h01, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, '0);
    ld(40'h40, 10'd18, 3'd3, W1);
    bus.mem_req_vld = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;

    // stall pattern: vld held high for 12 cycles
    acc        = 0;
    lows       = 0;
    last_low   = -1;
    spacing_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.mem_req_vld = 1'b1;
      bus.mem_req     = {40'h40, 10'(200 + acc), 5'h00, 3'd3, 1'b0, 1'b0, 64'h0};
      @(negedge clk);
      if (bus.mem_req_rdy) begin
        sbq.push_back('{mk(40'h40, 10'(200 + acc), 5'h00, 3'd3, W1, 1'b0, 1'b1, 64'h0),
                        cyc + LAT});
        acc++;
      end else begin
        lows++;
        if (last_low >= 0 && (i - last_low) != 4) spacing_ok = 1'b0;
        last_low = i;
      end
      @(posedge clk);
      #1;
    end
    bus.mem_req_vld = 1'b0;
    chk("stall_accepts", 64'(acc), 64'd9);
    chk("stall_low_cycles", 64'(lows), 64'd3);
    chk("stall_spacing", 64'(spacing_ok), 64'h1);
    repeat (LAT + 3) @(posedge clk);
    #1;

    // reset with loads in flight: anything not yet on the bus is dropped
    ld(40'h40, 10'd300, 3'd3, W1);
    ld(40'h40, 10'd301, 3'd3, W1);
    rst             = 1'b0;
    bus.mem_req_vld = 1'b0;
    while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("inreset_rdy", 64'(bus.mem_req_rdy), 64'h0);
      chk("inreset_resp_vld", 64'(bus.mem_resp_vld), 64'h0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rdy_after_second_release", 64'(bus.mem_req_rdy), 64'h1);
    repeat (LAT + 4) @(negedge clk);

    chk("scoreboard_empty", 64'(sbq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
